// File: rtl/program_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// program_loader
//   Writer side of the processor's user memory-load port. A framed byte stream
//   (length byte N, then N program bytes) is written into processor memory as
//   one-cycle write pulses, each followed by one idle cycle. After the last
//   byte the loader holds op high for RUN_CYCLES cycles, then pulses done.
//
//   Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN
//     When defined, one checksum byte (XOR of the program bytes) follows the
//     program. A mismatch sets the sticky error flag and skips the run.
//     When undefined, no checksum byte is expected and error is tied low.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   s_data    in   stream byte (length byte uses the low 8 bits)
//   s_valid   in   s_data valid
//   s_ready   out  loader accepts s_data this cycle
//   mem_data  out  write data to processor in_data
//   mem_addr  out  write address to processor user_address
//   mem_we    out  write strobe to processor user_write_memory
//   op        out  processor run enable
//   busy      out  high in every state except IDLE
//   done      out  one-cycle pulse when the run window ends
//   error     out  sticky checksum mismatch flag
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int          ADDR_W     = 8,
  parameter int          DATA_W     = 8,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned RUN_CYCLES = 22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              op,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);
  localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_GAP, S_CHECK, S_RUN, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          count_q, count_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
  logic                ready;
  logic                xfer;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   csum_q, csum_d;
  logic                error_q, error_d;
`endif

  // Handshake is decided from the state alone, so s_ready never drops while
  // s_valid is waiting in the same state. Reset forces it low immediately.
  assign s_ready = ready & reset;
  assign xfer    = s_valid & ready;

  // NOTE: every output of this block is given a default before the case
  // statement; a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    run_cnt_d  = '0;
    ready      = 1'b0;
    mem_we     = 1'b0;
    op         = 1'b0;
    done       = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    error_d    = error_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (xfer) begin
          count_d = s_data[7:0];
          addr_d  = START;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d  = '0;
          error_d = 1'b0;
          // An empty program still carries a checksum byte (expected 0x00).
          state_d = (s_data[7:0] == 8'd0) ? S_CHECK : S_LOAD;
`else
          state_d = (s_data[7:0] == 8'd0) ? S_RUN : S_LOAD;
`endif
        end
      end
      S_LOAD: begin
        ready = 1'b1;
        if (xfer) begin
          mem_data_d = s_data;
          mem_addr_d = addr_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ s_data;
`endif
          state_d    = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_we  = 1'b1;
        state_d = S_GAP;
      end
      S_GAP: begin
        // Address wraps naturally at 2^ADDR_W.
        addr_d  = addr_q + ADDR_W'(1);
        count_d = count_q - 8'd1;
        if (count_q == 8'd1) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_RUN;
`endif
        end else begin
          state_d = S_LOAD;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        ready = 1'b1;
        if (xfer) begin
          if (s_data == csum_q) begin
            state_d = S_RUN;
          end else begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
`endif
      S_RUN: begin
        op = 1'b1;
        if (run_cnt_q == RUN_LAST) begin
          state_d = S_DONE;
        end else begin
          run_cnt_d = run_cnt_q + RUN_W'(1);
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      addr_q     <= START;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      run_cnt_q  <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      run_cnt_q  <= run_cnt_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
      error_q    <= error_d;
`endif
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign busy     = (state_q != S_IDLE);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign error    = error_q;
`else
  assign error    = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_program_loader
//   Two loaders share one stream: u_dut0 loads at address 0x00, u_dutw at 0xFE
//   (address wrap). A frame-level model predicts every write, the run window,
//   done, busy, s_ready and error; one negedge process compares both DUTs
//   against it each cycle. Directed frames pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_program_loader;

  localparam int         RUN_CYCLES = 22;
  localparam logic [7:0] START_W    = 8'hFE;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;

  logic       s_ready, mem_we, op, busy, done, error;
  logic [7:0] mem_data, mem_addr;
  logic       s_ready_w, mem_we_w, op_w, busy_w, done_w, error_w;
  logic [7:0] mem_data_w, mem_addr_w;

  program_loader #(.ADDR_W(8), .DATA_W(8), .START_ADDR(0), .RUN_CYCLES(RUN_CYCLES)) u_dut0 (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mem_data(mem_data), .mem_addr(mem_addr), .mem_we(mem_we), .op(op),
    .busy(busy), .done(done), .error(error));

  program_loader #(.ADDR_W(8), .DATA_W(8), .START_ADDR(254), .RUN_CYCLES(RUN_CYCLES)) u_dutw (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_w),
    .mem_data(mem_data_w), .mem_addr(mem_addr_w), .mem_we(mem_we_w), .op(op_w),
    .busy(busy_w), .done(done_w), .error(error_w));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  typedef enum {P_IDLE, P_DATA, P_CSUM, P_RUN} phase_e;
  typedef struct {
    int         due;
    logic [7:0] a0;
    logic [7:0] aw;
    logic [7:0] d;
  } wr_t;

  wr_t        wq[$];      // writes still expected
  wr_t        wlog[$];    // writes observed, for directed checks
  phase_e     ph;
  int         cyc = 0;
  int         remaining, idx, ready_at, op_due;
  logic       in_frame, err_exp;
  logic [7:0] xsum;
  wr_t        last_wr;
  logic       prev_we;
  int         op_len, last_op_len, runs_done;
  logic       we_exp, op_exp, done_exp, rdy_exp;

  task automatic model_reset();
    wq.delete();
    ph       = P_IDLE;
    in_frame = 1'b0;
    err_exp  = 1'b0;
    prev_we  = 1'b0;
    op_len   = 0;
  endtask

  // A byte is transferred at the next posedge; outputs it causes appear
  // from the following cycle on.
  task automatic accept(input logic [7:0] b);
    case (ph)
      P_IDLE: begin
        in_frame  = 1'b1;
        err_exp   = 1'b0;
        xsum      = 8'h00;
        remaining = int'(b);
        idx       = 0;
        if (b == 8'h00) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          ph = P_CSUM; ready_at = cyc + 1;
`else
          ph = P_RUN;  op_due = cyc + 1;
`endif
        end else begin
          ph = P_DATA; ready_at = cyc + 1;
        end
      end
      P_DATA: begin
        wq.push_back('{due: cyc + 1, a0: 8'(idx), aw: START_W + 8'(idx), d: b});
        xsum ^= b;
        idx++;
        remaining--;
        // write cycle, gap cycle, then the next state
        if (remaining == 0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          ph = P_CSUM; ready_at = cyc + 3;
`else
          ph = P_RUN;  op_due = cyc + 3;
`endif
        end else begin
          ready_at = cyc + 3;
        end
      end
      P_CSUM: begin
        if (b == xsum) begin
          ph = P_RUN; op_due = cyc + 1;
        end else begin
          err_exp  = 1'b1;
          ph       = P_IDLE;
          in_frame = 1'b0;
        end
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      model_reset();
    end else begin
      we_exp   = (wq.size() > 0) && (wq[0].due == cyc);
      op_exp   = (ph == P_RUN) && (cyc >= op_due) && (cyc < op_due + RUN_CYCLES);
      done_exp = (ph == P_RUN) && (cyc == op_due + RUN_CYCLES);
      rdy_exp  = (ph == P_IDLE) || ((ph == P_DATA || ph == P_CSUM) && cyc >= ready_at);

      check("mem_we", mem_we, we_exp);
      check("mem_we_wrap", mem_we_w, we_exp);
      if (we_exp) begin
        check("mem_addr", mem_addr, wq[0].a0);
        check("mem_addr_wrap", mem_addr_w, wq[0].aw);
        check("mem_data", mem_data, wq[0].d);
        check("mem_data_wrap", mem_data_w, wq[0].d);
        last_wr = wq[0];
        wlog.push_back(wq[0]);
        void'(wq.pop_front());
      end else if (prev_we) begin
        check("gap_addr_hold", mem_addr, last_wr.a0);
        check("gap_data_hold", mem_data, last_wr.d);
      end
      prev_we = we_exp;

      check("op", op, op_exp);
      check("op_wrap", op_w, op_exp);
      check("done", done, done_exp);
      check("done_wrap", done_w, done_exp);
      check("busy", busy, in_frame);
      check("busy_wrap", busy_w, in_frame);
      check("s_ready", s_ready, rdy_exp);
      check("s_ready_wrap", s_ready_w, rdy_exp);
      check("error", error, err_exp);
      check("error_wrap", error_w, err_exp);

      if (op) op_len++;
      if (done) begin
        last_op_len = op_len;
        op_len = 0;
        runs_done++;
      end
      if (done_exp) begin
        ph = P_IDLE;
        in_frame = 1'b0;
      end
      if (s_valid && s_ready) accept(s_data);
    end
  end

  // ---------------- stimulus ----------------
  // All drive tasks start and end 1 time unit after a posedge.
  task automatic send_byte(input logic [7:0] b, input int idle);
    int t;
    if (idle > 0) begin
      s_valid = 1'b0;
      repeat (idle) @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = b;
    t = 0;
    @(negedge clk);
    while (!s_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) check("tx_timeout", 32'(t), 0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = 8'($urandom);
  endtask

  function automatic logic [7:0] xor_of(input logic [7:0] q[$]);
    logic [7:0] x = 8'h00;
    foreach (q[i]) x ^= q[i];
    return x;
  endfunction

  // Sends length + program; with the checksum build, also a checksum byte
  // (corrupted when good == 0).
  task automatic send_prog(input logic [7:0] prog[$], input int idle_max, input bit good);
    send_byte(8'(prog.size()), 0);
    foreach (prog[i]) send_byte(prog[i], (idle_max > 0) ? int'($urandom_range(0, idle_max)) : 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(good ? xor_of(prog) : (xor_of(prog) ^ 8'h01), 0);
`else
    if (!good) check("no_checksum_build", 1, 1);
`endif
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (busy && t < 300);
    if (t >= 300) check("idle_timeout", 32'(t), 0);
  endtask

  logic [7:0] prog[$];
  logic [7:0] exp1 [7] = '{8'h18, 8'hAA, 8'h19, 8'h55, 8'h0C, 8'h1C, 8'h1A};
  int         runs0;

  task automatic check_test1_log(input string tag);
    check({tag, "_writes"}, wlog.size(), 7);
    foreach (exp1[i]) begin
      if (i < wlog.size()) begin
        check({tag, "_addr"}, wlog[i].a0, 8'(i));
        check({tag, "_data"}, wlog[i].d, exp1[i]);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_mem_data"}, mem_data, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_op"}, op, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_wrap_addr"}, mem_addr_w, 0);
    check({tag, "_wrap_busy"}, busy_w, 0);
  endtask

  initial begin
    model_reset();
    runs_done = 0;
    last_op_len = 0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #2 reset = 1'b1;
    #1 check("ready_after_reset", s_ready, 1);
    @(posedge clk); #1;

    // Test 1: basic program
    prog = '{8'h18, 8'hAA, 8'h19, 8'h55, 8'h0C, 8'h1C, 8'h1A};
    check("test1_checksum_pin", xor_of(prog), 8'hF4);
    wlog.delete(); runs0 = runs_done;
    send_prog(prog, 0, 1'b1);
    wait_idle();
    check_test1_log("t1");
    check("t1_op_len", last_op_len, RUN_CYCLES);
    check("t1_runs", runs_done - runs0, 1);

    // Test 3: backpressure, s_valid low for two cycles before each byte
    wlog.delete(); runs0 = runs_done;
    send_byte(8'h07, 0);
    foreach (prog[i]) send_byte(prog[i], 2);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'hF4, 2);
`endif
    wait_idle();
    check_test1_log("t3");
    check("t3_runs", runs_done - runs0, 1);

    // Test 4: address wrap on the 0xFE loader
    prog = '{8'h11, 8'h22, 8'h33, 8'h44};
    wlog.delete();
    send_prog(prog, 1, 1'b1);
    wait_idle();
    check("t4_writes", wlog.size(), 4);
    if (wlog.size() == 4) begin
      check("t4_a0", wlog[0].aw, 8'hFE); check("t4_d0", wlog[0].d, 8'h11);
      check("t4_a1", wlog[1].aw, 8'hFF); check("t4_d1", wlog[1].d, 8'h22);
      check("t4_a2", wlog[2].aw, 8'h00); check("t4_d2", wlog[2].d, 8'h33);
      check("t4_a3", wlog[3].aw, 8'h01); check("t4_d3", wlog[3].d, 8'h44);
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Test 2: checksum mismatch skips the run; next length byte clears error
    prog = '{8'h18, 8'hAA, 8'h19, 8'h55, 8'h0C, 8'h1C, 8'h1A};
    runs0 = runs_done;
    send_byte(8'h07, 0);
    foreach (prog[i]) send_byte(prog[i], 0);
    send_byte(8'hF5, 0);
    wait_idle();
    repeat (30) @(posedge clk);
    #1;
    check("t2_error", error, 1);
    check("t2_no_run", runs_done - runs0, 0);
    send_byte(8'h00, 0);
    check("t2_error_cleared", error, 0);
    send_byte(8'h00, 0);
    check("t2_empty_op", op, 1);
    wait_idle();
`else
    // Test 6: empty program; the next frame is stalled by the run window
    wlog.delete(); runs0 = runs_done;
    send_byte(8'h00, 0);
    check("t6_op_next_cycle", op, 1);
    check("t6_stall_ready", s_ready, 0);
    prog = '{8'hA1, 8'hB2, 8'hC3};
    send_prog(prog, 0, 1'b1);
    wait_idle();
    check("t6_runs", runs_done - runs0, 2);
    check("t6_writes", wlog.size(), 3);
    check("t6_op_len", last_op_len, RUN_CYCLES);
`endif

    // Test 5: reset during the gap of the third byte
    send_byte(8'h07, 0);
    send_byte(8'h18, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h19, 0);
    check("t5_write_cycle", mem_we, 1);
    @(posedge clk); #2;
    check("t5_gap_busy", busy, 1);
    reset = 1'b0;
    #1 check_reset_outputs("t5_async");
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;
    prog = '{8'h18, 8'hAA, 8'h19, 8'h55, 8'h0C, 8'h1C, 8'h1A};
    wlog.delete();
    send_prog(prog, 0, 1'b1);
    wait_idle();
    check_test1_log("t5_again");

    // Reset during the run window drops op at once
    prog.delete();
    send_prog(prog, 0, 1'b1);
    repeat (5) @(posedge clk);
    #2 check("run_op_before_reset", op, 1);
    reset = 1'b0;
    #1 check("run_op_reset", op, 0);
    check("run_busy_reset", busy, 0);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;

    // Randomized frames, sometimes queued behind a running program
    for (int f = 0; f < 30; f++) begin
      int n = int'($urandom_range(0, 9));
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back(8'($urandom));
      send_prog(prog, 3, ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("pending_writes", wq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
